// File: rtl/fpu_pkg.sv
// fpu_pkg: shared field widths, exponent constants and FSM state encoding for the FP result path.
package fpu_pkg;
  localparam int EXP_W  = 10;
  localparam int IEXP_W = 12;
  localparam int MANT_W = 28;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam logic signed [IEXP_W-1:0] EXP_MAX = 12'sd255;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t NORM  = 2'd1;
  localparam state_t ROUND = 2'd2;
  localparam state_t DONE  = 2'd3;
endpackage

// File: rtl/fp_rne_rounder.sv
// fp_rne_rounder: round-to-nearest-even of a normalised mantissa and binary32 packing with flags.
module fp_rne_rounder
  import fpu_pkg::*;
(
  input  logic                     sign,
  input  logic signed [IEXP_W-1:0] exp_in,
  input  logic [26:0]              mant,
  output logic [31:0]              result,
  output logic [2:0]               flags
);
  logic inc, nx, uf, of;
  logic [24:0] r;
  logic [23:0] rn;
  logic signed [IEXP_W-1:0] e;
  logic [7:0] field;
  always_comb begin
    inc    = mant[2] & (mant[1] | mant[0] | mant[3]);
    r      = {1'b0, mant[26:3]} + {24'b0, inc};
    rn     = r[24] ? r[24:1] : r[23:0];
    e      = r[24] ? exp_in + 12'sd1 : exp_in;
    nx     = |mant[2:0];
    uf     = nx & ~mant[26];
    of     = e >= EXP_MAX;
    // a subnormal that rounds into bit 23 already carries exp=1, so the normal path encodes it
    field  = rn[23] ? e[7:0] : 8'd0;
    result = of ? {sign, 8'hFF, 23'b0} : {sign, field, rn[22:0]};
    flags  = of ? 3'b101 : {1'b0, uf, nx};
  end
endmodule

// File: rtl/fp_result_packer.sv
// fp_result_packer: normalises, rounds and packs an extended-precision result into binary32 with a ready/valid FSM.
module fp_result_packer
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_special,
  input  logic [31:0]       in_special_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
);
  state_t state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d, mant_shr;
  logic signed [IEXP_W-1:0] exp_q, exp_d;
  logic sign_q, sign_d;
  logic [31:0] result_q, result_d, rnd_result;
  logic [2:0] flags_q, flags_d, rnd_flags;
  logic accept;

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign accept     = in_valid & in_ready;
  // carry and underflow shifts both keep the dropped bit as sticky
  assign mant_shr   = {1'b0, mant_q[MANT_W-1:1]} | {27'b0, mant_q[0]};

  fp_rne_rounder u_rnd (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mant   (mant_q[26:0]),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (accept) begin
        sign_d = in_sign;
        if (in_special) begin
          result_d = in_special_val;
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if (in_mant == '0) begin
          result_d = {in_sign, 31'b0};
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if ($signed(in_exp) < -10'sd25) begin
          mant_d  = 28'd1;
          exp_d   = 12'sd1;
          state_d = NORM;
        end else begin
          mant_d  = in_mant;
          exp_d   = {{(IEXP_W-EXP_W){in_exp[EXP_W-1]}}, in_exp};
          state_d = NORM;
        end
      end
      NORM: if (mant_q[27]) begin
        mant_d  = mant_shr;
        exp_d   = exp_q + 12'sd1;
        state_d = ROUND;
      end else if (exp_q < 12'sd1) begin
        mant_d = mant_shr;
        exp_d  = exp_q + 12'sd1;
      end else if (!mant_q[26] && exp_q > 12'sd1) begin
        mant_d = {mant_q[MANT_W-2:0], 1'b0};
        exp_d  = exp_q - 12'sd1;
      end else begin
        state_d = ROUND;
      end
      ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_result_packer.sv
// tb_fp_result_packer: directed and randomized checks of fp_result_packer against an arithmetic reference model.
module tb_fp_result_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_sign = 1'b0, in_special = 1'b0;
  logic [9:0] in_exp = '0;
  logic [27:0] in_mant = '0;
  logic [31:0] in_special_val = '0, out_result;
  logic out_valid, out_ready = 1'b0;
  logic [2:0] out_flags;
  int checks = 0, failures = 0;

  fp_result_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant), .in_special(in_special), .in_special_val(in_special_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // value = mant * 2^(exp-153); normalise, round half-to-even, pack
  function automatic logic [34:0] model(input logic s, input logic signed [9:0] ex, input logic [27:0] m,
                                        input logic sp, input logic [31:0] sv);
    longint e, mm, r, g;
    logic nx, uf;
    logic [7:0] field;
    if (sp) return {3'b000, sv};
    if (m == 0) return {3'b000, s, 31'b0};
    e = longint'(ex);
    mm = longint'(m);
    if (e < -25) begin
      mm = 1;
      e = 1;
    end
    if (mm >= (64'sd1 << 27)) begin
      mm = (mm >> 1) | (mm & 1);
      e++;
    end else begin
      if (e < 1) begin
        mm = (mm >> (1 - e)) | longint'((mm & ((64'sd1 << (1 - e)) - 1)) != 0);
        e = 1;
      end
      while (e > 1 && mm < (64'sd1 << 26)) begin
        mm = mm * 2;
        e--;
      end
    end
    g = mm & 7;
    nx = g != 0;
    uf = nx && mm < (64'sd1 << 26);
    r = mm >> 3;
    if (g > 4 || (g == 4 && (r & 1) == 1)) r++;
    if (r >= (64'sd1 << 24)) begin
      r = r >> 1;
      e++;
    end
    if (e >= 255) return {3'b101, s, 8'hFF, 23'b0};
    field = (r >= (64'sd1 << 23)) ? e[7:0] : 8'd0;
    return {1'b0, uf, nx, s, field, r[22:0]};
  endfunction

  task automatic issue(input logic s, input logic [9:0] ex, input logic [27:0] m,
                       input logic sp, input logic [31:0] sv);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sign = s; in_exp = ex; in_mant = m; in_special = sp; in_special_val = sv;
    @(posedge clk);
    #1;
    // keep offering garbage while busy; it must be ignored
    in_sign = ~s; in_exp = 10'($urandom); in_mant = 28'($urandom); in_special = 1'($urandom);
    in_special_val = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input logic s, input logic [9:0] ex, input logic [27:0] m, input logic sp,
                     input logic [31:0] sv, input int hold, input logic [31:0] want_res, input logic [2:0] want_flg);
    int cyc;
    issue(s, ex, m, sp, sv);
    wait_done(cyc);
    check("out_valid", 32'(out_valid), 32'd1);
    if (sp || m == 0) check("latency_t1", 32'(cyc), 32'd1);
    else check("latency_le30", 32'(cyc <= 30), 32'd1);
    check("result", out_result, want_res);
    check("flags", 32'(out_flags), 32'(want_flg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", out_result, want_res);
      check("hold_flags", 32'(out_flags), 32'(want_flg));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("released", 32'({out_valid, in_ready}), 32'd1);
  endtask

  task automatic run_model(input logic s, input logic [9:0] ex, input logic [27:0] m, input logic sp,
                           input logic [31:0] sv, input int hold);
    logic [34:0] w;
    w = model(s, ex, m, sp, sv);
    run(s, ex, m, sp, sv, hold, w[31:0], w[34:32]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_result", out_result, 32'd0);
    check("reset_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 10'd0, 28'd0, 1'b1, 32'h7FC00000, 0, 32'h7FC00000, 3'b000);
    run(1'b1, 10'd50, 28'd0, 1'b0, 32'd0, 0, 32'h80000000, 3'b000);
    run(1'b0, 10'd127, 28'h8000000, 1'b0, 32'd0, 5, 32'h40000000, 3'b000);
    run(1'b0, 10'd127, 28'h0000008, 1'b0, 32'd0, 0, 32'h34000000, 3'b000);
    run(1'b0, 10'd254, 28'hFFFFFFF, 1'b0, 32'd0, 0, 32'h7F800000, 3'b101);
    run(1'b0, 10'd127, 28'h4000004, 1'b0, 32'd0, 0, 32'h3F800000, 3'b001);
    run(1'b0, 10'd127, 28'h400000C, 1'b0, 32'd0, 0, 32'h3F800002, 3'b001);
    run(1'b1, -10'sd30, 28'h0000123, 1'b0, 32'd0, 0, 32'h80000000, 3'b011);
    run(1'b0, 10'd1, 28'h3FFFFFC, 1'b0, 32'd0, 0, 32'h00800000, 3'b011);

    issue(1'b0, 10'd127, 28'h0000008, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    reset_pulse();
    run(1'b0, 10'd127, 28'h4000004, 1'b0, 32'd0, 0, 32'h3F800000, 3'b001);

    issue(1'b0, 10'd0, 28'd0, 1'b1, 32'h12345678);
    wait_done(cyc);
    check("pre_rst_done", 32'(out_valid), 32'd1);
    reset_pulse();
    run(1'b0, 10'd127, 28'h8000000, 1'b0, 32'd0, 1, 32'h40000000, 3'b000);

    for (int i = 0; i < 150; i++) begin
      int ei, mode;
      logic [27:0] m;
      logic sp;
      mode = int'($urandom_range(0, 3));
      ei = mode == 0 ? int'($urandom_range(100, 160)) :
           mode == 1 ? int'($urandom_range(0, 35)) - 30 :
           mode == 2 ? int'($urandom_range(240, 260)) : int'($urandom_range(0, 1023)) - 512;
      m = 28'($urandom);
      if ($urandom_range(0, 1) == 1) m = m >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) m = '0;
      if (ei < 1 && ei >= -25) m[27] = 1'b0;
      sp = $urandom_range(0, 15) == 0;
      run_model(1'($urandom), 10'(ei), m, sp, $urandom, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
